// File: rtl/envelope_generator.sv
// AY/YM style envelope generator with integrated period divider, shape latch and hold status.
// Level is registered (one cycle after a step or restart); no backpressure, enable only gates advance.
module envelope_generator #(
  parameter int PERIOD_BITS   = 16,
  parameter int ENVELOPE_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     restart,
  input  logic                     hold,
  input  logic                     alternate,
  input  logic                     attack,
  input  logic                     continue_,
  input  logic [PERIOD_BITS-1:0]   period,
  output logic [ENVELOPE_BITS-1:0] out,
  output logic                     holding,
  output logic                     cycle_done
);

  localparam logic [ENVELOPE_BITS-1:0] MAX     = '1;
  localparam logic [ENVELOPE_BITS-1:0] CNT_ONE = 1;
  localparam logic [PERIOD_BITS-1:0]   DIV_ONE = 1;

  logic [PERIOD_BITS-1:0]   div_q, div_d;
  logic [ENVELOPE_BITS-1:0] cnt_q, cnt_d;
  logic                     inv_q, inv_d;
  logic                     stopped_q, stopped_d;
  logic                     s_hold_q, s_hold_d;
  logic                     s_alt_q, s_alt_d;
  logic                     s_att_q, s_att_d;
  logic                     s_cont_q, s_cont_d;
  logic                     cycle_done_q, cycle_done_d;

  logic [PERIOD_BITS-1:0]   div_lim;
  logic                     step;
  logic                     h_eff;
  logic                     a_eff;

  // Non-continuing shapes always hold, and their direction flip comes from attack.
  assign h_eff = s_hold_q | ~s_cont_q;
  assign a_eff = s_cont_q ? s_alt_q : s_att_q;

  // Period 0 behaves as period 1; the >= compare lets a shortened period act at once.
  assign div_lim = (period == '0) ? '0 : (period - DIV_ONE);
  assign step    = enable && (div_q >= div_lim);

  always_comb begin
    div_d        = div_q;
    cnt_d        = cnt_q;
    inv_d        = inv_q;
    stopped_d    = stopped_q;
    s_hold_d     = s_hold_q;
    s_alt_d      = s_alt_q;
    s_att_d      = s_att_q;
    s_cont_d     = s_cont_q;
    cycle_done_d = 1'b0;

    if (restart) begin
      s_hold_d  = hold;
      s_alt_d   = alternate;
      s_att_d   = attack;
      s_cont_d  = continue_;
      div_d     = '0;
      cnt_d     = '0;
      stopped_d = 1'b0;
      inv_d     = ~attack;
    end else if (enable) begin
      div_d = step ? '0 : (div_q + DIV_ONE);
      if (step && !stopped_q) begin
        if (cnt_q != MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cycle_done_d = 1'b1;
          inv_d        = inv_q ^ a_eff;
          if (h_eff) begin
            stopped_d = 1'b1;
          end else begin
            cnt_d = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q        <= '0;
      cnt_q        <= MAX;
      inv_q        <= 1'b1;
      stopped_q    <= 1'b1;
      s_hold_q     <= 1'b0;
      s_alt_q      <= 1'b0;
      s_att_q      <= 1'b0;
      s_cont_q     <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      inv_q        <= inv_d;
      stopped_q    <= stopped_d;
      s_hold_q     <= s_hold_d;
      s_alt_q      <= s_alt_d;
      s_att_q      <= s_att_d;
      s_cont_q     <= s_cont_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign out        = inv_q ? (MAX - cnt_q) : cnt_q;
  assign holding    = stopped_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_envelope_generator.sv
// Directed bench for envelope_generator: 4-bit and 5-bit instances share stimulus.
module tb_envelope_generator;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        restart;
  logic        hold;
  logic        alternate;
  logic        attack;
  logic        continue_;
  logic [15:0] period;
  logic [3:0]  out;
  logic        holding;
  logic        cycle_done;
  logic [4:0]  out5;
  logic        holding5;
  logic        cycle_done5;

  int checks = 0;
  int errors = 0;

  envelope_generator #(.PERIOD_BITS(16), .ENVELOPE_BITS(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .restart(restart),
    .hold(hold), .alternate(alternate), .attack(attack), .continue_(continue_),
    .period(period), .out(out), .holding(holding), .cycle_done(cycle_done)
  );

  envelope_generator #(.PERIOD_BITS(16), .ENVELOPE_BITS(5)) dut5 (
    .clk(clk), .reset(reset), .enable(enable), .restart(restart),
    .hold(hold), .alternate(alternate), .attack(attack), .continue_(continue_),
    .period(period), .out(out5), .holding(holding5), .cycle_done(cycle_done5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // shp = {continue, attack, alternate, hold}
  task automatic do_restart(input logic [3:0] shp);
    {continue_, attack, alternate, hold} = shp;
    restart = 1'b1;
    step_clk();
    restart = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (out !== 4'd0 || holding !== 1'b1 || cycle_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out=%0d holding=%0b cd=%0b, want 0 1 0", out, holding, cycle_done);
    end
    checks++;
    if (out5 !== 5'd0 || holding5 !== 1'b1) begin
      errors++;
      $display("FAIL reset_state5: out=%0d holding=%0b, want 0 1", out5, holding5);
    end
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;
    period = 16'd1;
    step_clk();
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (out !== 4'd0 || holding !== 1'b1 || cycle_done !== 1'b0) begin
        errors++;
        $display("FAIL idle_silent[%0d]: out=%0d holding=%0b cd=%0b, want 0 1 0", i, out, holding, cycle_done);
      end
      step_clk();
    end
  endtask

  task automatic test_async_reset();
    period = 16'd1;
    enable = 1'b1;
    do_restart(4'b1000);
    repeat (5) step_clk();
    checks++;
    if (out !== 4'd10) begin
      errors++;
      $display("FAIL pre_reset_level: out=%0d, want 10", out);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out !== 4'd0 || holding !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: out=%0d holding=%0b, want 0 1", out, holding);
    end
    step_clk();
    reset = 1'b0;
    step_clk();
  endtask

  task automatic test_saw_down();
    int e;
    period = 16'd1;
    enable = 1'b1;
    do_restart(4'b1000);
    for (int i = 0; i < 48; i++) begin
      e = 15 - (i % 16);
      checks++;
      if (out !== 4'(e) || holding !== 1'b0) begin
        errors++;
        $display("FAIL saw_down_level[%0d]: out=%0d holding=%0b, want %0d 0", i, out, holding, e);
      end
      checks++;
      if (cycle_done !== ((i % 16 == 0) && (i > 0))) begin
        errors++;
        $display("FAIL saw_down_cd[%0d]: cd=%0b, want %0b", i, cycle_done, (i % 16 == 0) && (i > 0));
      end
      step_clk();
    end
  endtask

  task automatic test_triangle();
    int e;
    period = 16'd1;
    enable = 1'b1;
    do_restart(4'b1110);
    for (int i = 0; i < 50; i++) begin
      e = ((i / 16) % 2 == 1) ? 15 - (i % 16) : (i % 16);
      checks++;
      if (out !== 4'(e) || holding !== 1'b0) begin
        errors++;
        $display("FAIL triangle_level[%0d]: out=%0d holding=%0b, want %0d 0", i, out, holding, e);
      end
      checks++;
      if (cycle_done !== ((i % 16 == 0) && (i > 0))) begin
        errors++;
        $display("FAIL triangle_cd[%0d]: cd=%0b", i, cycle_done);
      end
      step_clk();
    end
  endtask

  task automatic test_hold_up();
    int e;
    int pulses;
    pulses = 0;
    period = 16'd1;
    enable = 1'b1;
    do_restart(4'b1011);
    for (int i = 0; i < 32; i++) begin
      e = (i < 16) ? 15 - i : 15;
      if (cycle_done === 1'b1) pulses++;
      checks++;
      if (out !== 4'(e) || holding !== (i >= 16)) begin
        errors++;
        $display("FAIL hold_up[%0d]: out=%0d holding=%0b, want %0d %0b", i, out, holding, e, i >= 16);
      end
      checks++;
      if (cycle_done !== (i == 16)) begin
        errors++;
        $display("FAIL hold_up_cd[%0d]: cd=%0b, want %0b", i, cycle_done, i == 16);
      end
      step_clk();
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL hold_up_pulses: got %0d, want 1", pulses);
    end
  endtask

  task automatic test_oneshots();
    int e;
    period = 16'd1;
    enable = 1'b1;
    do_restart(4'b0110);
    for (int i = 0; i < 24; i++) begin
      e = (i < 16) ? i : 0;
      checks++;
      if (out !== 4'(e) || holding !== (i >= 16)) begin
        errors++;
        $display("FAIL attack_drop[%0d]: out=%0d holding=%0b, want %0d %0b", i, out, holding, e, i >= 16);
      end
      step_clk();
    end
    do_restart(4'b0011);
    for (int i = 0; i < 24; i++) begin
      e = (i < 16) ? 15 - i : 0;
      checks++;
      if (out !== 4'(e) || holding !== (i >= 16)) begin
        errors++;
        $display("FAIL decay_drop[%0d]: out=%0d holding=%0b, want %0d %0b", i, out, holding, e, i >= 16);
      end
      step_clk();
    end
  endtask

  task automatic test_period();
    int e;
    period = 16'd3;
    enable = 1'b0;
    do_restart(4'b1000);
    for (int j = 1; j <= 24; j++) begin
      enable = (j % 2 == 1);
      step_clk();
      e = 15 - (((j + 1) / 2) / 3);
      checks++;
      if (out !== 4'(e)) begin
        errors++;
        $display("FAIL period3[%0d]: out=%0d, want %0d", j, out, e);
      end
    end
    period = 16'd0;
    enable = 1'b1;
    do_restart(4'b1000);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out !== 4'(15 - i)) begin
        errors++;
        $display("FAIL period0[%0d]: out=%0d, want %0d", i, out, 15 - i);
      end
      step_clk();
    end
    period = 16'd1000;
    do_restart(4'b1000);
    repeat (500) step_clk();
    checks++;
    if (out !== 4'd15) begin
      errors++;
      $display("FAIL period1000_wait: out=%0d, want 15", out);
    end
    period = 16'd2;
    step_clk();
    checks++;
    if (out !== 4'd14) begin
      errors++;
      $display("FAIL period_shrink: out=%0d, want 14", out);
    end
    step_clk();
    checks++;
    if (out !== 4'd14) begin
      errors++;
      $display("FAIL period2_gap: out=%0d, want 14", out);
    end
    step_clk();
    checks++;
    if (out !== 4'd13) begin
      errors++;
      $display("FAIL period2_step: out=%0d, want 13", out);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    period = 16'd1;
    enable = 1'b1;
    do_restart(4'b1000);
    repeat (6) step_clk();
    do_restart(4'b1100);
    {continue_, attack, alternate, hold} = 4'b0000;
    for (int i = 0; i < 22; i++) begin
      e = i % 16;
      checks++;
      if (out !== 4'(e) || holding !== 1'b0) begin
        errors++;
        $display("FAIL restart_ramp[%0d]: out=%0d holding=%0b, want %0d 0", i, out, holding, e);
      end
      step_clk();
    end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step_clk();
      checks++;
      if (out !== 4'd6 || cycle_done !== 1'b0) begin
        errors++;
        $display("FAIL enable_freeze[%0d]: out=%0d cd=%0b, want 6 0", i, out, cycle_done);
      end
    end
    enable = 1'b1;
    step_clk();
    checks++;
    if (out !== 4'd7) begin
      errors++;
      $display("FAIL enable_resume: out=%0d, want 7", out);
    end
  endtask

  task automatic test_ebits5();
    int e;
    period = 16'd1;
    enable = 1'b1;
    do_restart(4'b1000);
    for (int i = 0; i < 70; i++) begin
      e = 31 - (i % 32);
      checks++;
      if (out5 !== 5'(e) || holding5 !== 1'b0) begin
        errors++;
        $display("FAIL ebits5_level[%0d]: out=%0d holding=%0b, want %0d 0", i, out5, holding5, e);
      end
      checks++;
      if (cycle_done5 !== ((i % 32 == 0) && (i > 0))) begin
        errors++;
        $display("FAIL ebits5_cd[%0d]: cd=%0b", i, cycle_done5);
      end
      step_clk();
    end
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    restart   = 1'b0;
    hold      = 1'b0;
    alternate = 1'b0;
    attack    = 1'b0;
    continue_ = 1'b0;
    period    = 16'd0;
    #2 reset = 1'b1;
    #1;
    test_reset();
    test_async_reset();
    test_saw_down();
    test_triangle();
    test_hold_up();
    test_oneshots();
    test_period();
    test_back_to_back();
    test_ebits5();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/envelope_generator.md
Name: envelope_generator

Overview:
Parametrised next-generation envelope generator for the PSG voice path. It produces the AY-3-8910 style 16-step envelope (ENVELOPE_BITS=4) or the YM2149 style 32-step envelope (ENVELOPE_BITS=5), with an integrated period divider. It adds the following over the current envelope block: a shape-restart strobe with latched shape, defined period-0 behaviour, a clean hold state with status flags, and a cycle-complete pulse. It sits between the register file (period, shape, restart on shape write) and the per-channel amplitude mux.

Parameters:
PERIOD_BITS, 16, width of the envelope period and internal divider.
ENVELOPE_BITS, 4, envelope step resolution (4 gives 16 steps, 5 gives 32 steps). MAX = 2^ENVELOPE_BITS-1.

Ports:
clk  input  1  system clock; the only clock.
reset  input  1  asynchronous, active-high reset.
enable  input  1  clock-enable tick from the master prescaler; divider and stepping advance only when high.
restart  input  1  one-cycle strobe on shape-register write; latches the shape and restarts the envelope.
hold  input  1  shape bit 0.
alternate  input  1  shape bit 1.
attack  input  1  shape bit 2.
continue_  input  1  shape bit 3.
period  input  PERIOD_BITS  envelope period in enable ticks; 0 is treated as 1.
out  output  ENVELOPE_BITS  current envelope level.
holding  output  1  high while the envelope is frozen at its final level.
cycle_done  output  1  one-cycle pulse on every step that completes a ramp (counter at MAX).

Behaviour:
- Registers: div[PERIOD_BITS-1:0], cnt[ENVELOPE_BITS-1:0], inv, stopped, and latched shape bits s_hold, s_alt, s_att, s_cont.
- Async reset, effective immediately: div=0, cnt=MAX, inv=1, stopped=1, shape=0000, cycle_done=0. Result: out=0 and holding=1. The block stays silent until the first restart.
- Effective shape, combinational from the latched bits:
  - h_eff = s_hold | ~s_cont
  - a_eff = s_cont ? s_alt : s_att
- Divider: on enable, if div >= max(period,1)-1 then div<=0 and step=1 for that cycle; otherwise div<=div+1. The >= compare means a reduced period takes effect at once, with no long wrap.
- Period 0 and period 1 both give one step per enable tick.
- Step when stopped=0:
  - If cnt != MAX: cnt<=cnt+1.
  - If cnt == MAX and h_eff=0: cnt<=0 and inv<=inv^a_eff.
  - If cnt == MAX and h_eff=1: cnt stays MAX, inv<=inv^a_eff, stopped<=1.
  - Every step with cnt==MAX asserts cycle_done (registered, high during the following cycle). This includes the step that enters hold.
- Step when stopped=1: no change to cnt or inv. cycle_done stays 0. The divider keeps running.
- out = inv ? MAX-cnt : cnt (combinational from registers). holding = stopped.
- Restart (sampled on the clock edge, independent of enable):
  - Latch the shape inputs.
  - div<=0, cnt<=0, stopped<=0, inv<=~attack, cycle_done<=0.
  - First level visible the cycle after the strobe: MAX when attack=0, 0 when attack=1.
  - Restart wins over a step in the same cycle; that step is discarded.
- Shape inputs changing without restart have no effect.
- enable low freezes div, cnt, inv and stopped. Restart and reset still act.
- Resulting held levels: \___ = 0; \``` = MAX; /``` = MAX; /___ = 0. Continue=0 shapes resolve to \___ (attack=0) and /___ (attack=1).
- Alternating shapes repeat the peak/trough level once at each turn, e.g. …,14,15,15,14,…, as on the AY.

Test Plan:
- Reset then idle, enable=1, period=1: out=0, holding=1, cycle_done never pulses. Async reset asserted mid-ramp: out=0 immediately, without waiting for a clock edge.
- ENVELOPE_BITS=4, period=1, restart with shape 1000, enable=1: out=15,14,…,0,15,14,… repeating. cycle_done pulses once per 16 steps, on the cycle after out=0→15. holding=0 throughout.
- Shape 1110, period=1: out=0,1,…,15,15,14,…,0,0,1,…
- Shape 1011: out=15…0, then 15 held. holding rises with the final step. cycle_done pulses exactly once.
- Shape 01xx: out=0…15, then 0 held.
- Period=3, enable high every other cycle: one step per 3 enable ticks (6 clocks). Period=0 gives the same step timing as period=1. Changing period from 1000 to 2 while div=500: step on the next enable tick.
- Restart strobe mid-ramp coincident with a step, new shape 1100: the step is ignored and out=0 the next cycle, then ramps up. Changing shape inputs without restart leaves out unaffected.
- ENVELOPE_BITS=5, shape 1000, period=1: out=31…0 wrapping. cycle_done every 32 steps.
